// File: rtl/timer_io_arbiter_pkg.sv
// Shared types for the machine-timer IO arbiter: lock state encoding and
// timer word-select codes for the 32-bit mtime/mtimecmp port.
package timer_io_arbiter_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } arb_state_e;

  localparam logic [1:0] MTIME_LO    = 2'b00;
  localparam logic [1:0] MTIME_HI    = 2'b01;
  localparam logic [1:0] MTIMECMP_LO = 2'b10;
  localparam logic [1:0] MTIMECMP_HI = 2'b11;

endpackage

// File: rtl/timer_arb_lock_counter.sv
// Idle counter for the lock owner: saturating count with clear, flags when
// the count equals LOCK_TIMEOUT.
module timer_arb_lock_counter
  import timer_io_arbiter_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic clk,
  input  logic resetb,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [CNT_W-1:0] cnt;

  // Clear has priority; the count holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign term = (cnt == CNT_W'(LOCK_TIMEOUT));

endmodule

// File: rtl/timer_io_arbiter.sv
// Round-robin arbiter with hi/lo lock in front of the 32-bit machine-timer port.
// Optional forced lock release via idle timeout: define TIMER_ARB_TIMEOUT_EN.
module timer_io_arbiter
  import timer_io_arbiter_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic        r0_lock,
  input  logic [1:0]  r0_addr_3_2,
  input  logic [31:0] r0_din,
  output logic        r0_gnt,
  output logic [31:0] r0_rdata,
  output logic        r0_rvalid,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic        r1_lock,
  input  logic [1:0]  r1_addr_3_2,
  input  logic [31:0] r1_din,
  output logic        r1_gnt,
  output logic [31:0] r1_rdata,
  output logic        r1_rvalid,
  output logic [1:0]  t_addr_3_2,
  output logic        t_we,
  output logic [31:0] t_din,
  input  logic [31:0] t_dout,
  output logic        lock_timeout
);

  arb_state_e state, state_nxt;
  logic       prio, prio_nxt;
  logic       timeout_fire;
  logic       timeout_nxt;

`ifdef TIMER_ARB_TIMEOUT_EN
  logic locked, owner_req, cnt_term;

  assign locked    = (state != UNLOCKED);
  assign owner_req = (state == LOCKED1) ? r1_req : r0_req;

  // An owner request in the terminal cycle clears the count, so req beats timeout.
  timer_arb_lock_counter #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_lock_cnt (
    .clk   (clk),
    .resetb(resetb),
    .clr   (~locked | owner_req | cnt_term),
    .en    (locked & ~owner_req),
    .term  (cnt_term)
  );

  assign timeout_fire = locked & ~owner_req & cnt_term;
`else
  logic unused_cfg;
  assign unused_cfg   = ^{LOCK_TIMEOUT[0], CNT_W[0]};
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    case (state)
      LOCKED0: r0_gnt = r0_req;
      LOCKED1: r1_gnt = r1_req;
      default: begin
        if (r0_req && r1_req) begin
          r0_gnt = ~prio;
          r1_gnt = prio;
        end else begin
          r0_gnt = r0_req;
          r1_gnt = r1_req;
        end
      end
    endcase
  end

  assign t_addr_3_2 = r1_gnt ? r1_addr_3_2 : r0_addr_3_2;
  assign t_din      = r1_gnt ? r1_din : r0_din;
  assign t_we       = (r0_gnt & r0_we) | (r1_gnt & r1_we);

  // A granted access decides the lock; prio only moves when ownership is given up.
  always_comb begin
    state_nxt   = state;
    prio_nxt    = prio;
    timeout_nxt = 1'b0;
    if (r0_gnt) begin
      state_nxt = r0_lock ? LOCKED0 : UNLOCKED;
      if (!r0_lock) prio_nxt = 1'b1;
    end else if (r1_gnt) begin
      state_nxt = r1_lock ? LOCKED1 : UNLOCKED;
      if (!r1_lock) prio_nxt = 1'b0;
    end else if (timeout_fire) begin
      state_nxt   = UNLOCKED;
      prio_nxt    = (state == LOCKED0);
      timeout_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state        <= UNLOCKED;
      prio         <= 1'b0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      prio         <= prio_nxt;
      lock_timeout <= timeout_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r0_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rvalid <= 1'b0;
      r1_rdata  <= '0;
    end else begin
      r0_rvalid <= r0_gnt & ~r0_we;
      r1_rvalid <= r1_gnt & ~r1_we;
      if (r0_gnt && !r0_we) r0_rdata <= t_dout;
      if (r1_gnt && !r1_we) r1_rdata <= t_dout;
    end
  end

endmodule

// File: tb/tb_timer_io_arbiter.sv
// Directed, scoreboard-checked bench for timer_io_arbiter with a small timer model.
// Covers both builds of TIMER_ARB_TIMEOUT_EN.
module tb_timer_io_arbiter;
  import timer_io_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetb;
  logic        r0_req, r0_we, r0_lock;
  logic [1:0]  r0_addr_3_2;
  logic [31:0] r0_din;
  logic        r0_gnt, r0_rvalid;
  logic [31:0] r0_rdata;
  logic        r1_req, r1_we, r1_lock;
  logic [1:0]  r1_addr_3_2;
  logic [31:0] r1_din;
  logic        r1_gnt, r1_rvalid;
  logic [31:0] r1_rdata;
  logic [1:0]  t_addr_3_2;
  logic        t_we;
  logic [31:0] t_din;
  logic [31:0] t_dout;
  logic        lock_timeout;

  typedef struct packed {
    logic        req;
    logic [31:0] data;
  } rd_item_t;

  rd_item_t sb[$];
  int testCount = 0;
  int failCount = 0;

  logic [31:0] tmr [4] = '{32'h0000_0005, 32'hA5A5_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  always #5 clk = ~clk;

  always @(posedge clk) if (t_we) tmr[t_addr_3_2] <= t_din;
  assign t_dout = tmr[t_addr_3_2];

  timer_io_arbiter #(.LOCK_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .resetb(resetb),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr_3_2(r0_addr_3_2),
    .r0_din(r0_din), .r0_gnt(r0_gnt), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr_3_2(r1_addr_3_2),
    .r1_din(r1_din), .r1_gnt(r1_gnt), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
    .t_addr_3_2(t_addr_3_2), .t_we(t_we), .t_din(t_din), .t_dout(t_dout),
    .lock_timeout(lock_timeout)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic setR0(input logic req, input logic we, input logic lock,
                       input logic [1:0] addr, input logic [31:0] din);
    r0_req = req; r0_we = we; r0_lock = lock; r0_addr_3_2 = addr; r0_din = din;
  endtask

  task automatic setR1(input logic req, input logic we, input logic lock,
                       input logic [1:0] addr, input logic [31:0] din);
    r1_req = req; r1_we = we; r1_lock = lock; r1_addr_3_2 = addr; r1_din = din;
  endtask

  task automatic checkOutput();
    rd_item_t it;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      if (it.req == 1'b0) begin
        checkValue("r0_rvalid", 32'(r0_rvalid), 32'd1);
        checkValue("r0_rdata", r0_rdata, it.data);
        checkValue("r1_rvalid", 32'(r1_rvalid), 32'd0);
      end else begin
        checkValue("r1_rvalid", 32'(r1_rvalid), 32'd1);
        checkValue("r1_rdata", r1_rdata, it.data);
        checkValue("r0_rvalid", 32'(r0_rvalid), 32'd0);
      end
    end else begin
      checkValue("r0_rvalid_idle", 32'(r0_rvalid), 32'd0);
      checkValue("r1_rvalid_idle", 32'(r1_rvalid), 32'd0);
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic applyStimulus(input logic e_g0, input logic e_g1, input logic e_to);
    @(negedge clk);
    checkValue("r0_gnt", 32'(r0_gnt), 32'(e_g0));
    checkValue("r1_gnt", 32'(r1_gnt), 32'(e_g1));
    checkValue("lock_timeout", 32'(lock_timeout), 32'(e_to));
    if (e_g0 && !r0_we) sb.push_back('{req: 1'b0, data: tmr[r0_addr_3_2]});
    if (e_g1 && !r1_we) sb.push_back('{req: 1'b1, data: tmr[r1_addr_3_2]});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    resetb = 1'b0;
    setR0(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    setR1(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    checkValue("rst_r0_gnt", 32'(r0_gnt), 32'd0);
    checkValue("rst_r1_gnt", 32'(r1_gnt), 32'd0);
    checkValue("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
    checkValue("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
    checkValue("rst_r0_rdata", r0_rdata, 32'd0);
    checkValue("rst_r1_rdata", r1_rdata, 32'd0);
    checkValue("rst_lock_timeout", 32'(lock_timeout), 32'd0);
    checkValue("rst_t_we", 32'(t_we), 32'd0);
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single read after reset.
    doReset();
    setR0(1'b1, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkValue("r1_rdata_untouched", r1_rdata, 32'd0);
    setR0(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Round-robin alternation starting with requester 0.
    doReset();
    setR0(1'b1, 1'b0, 1'b0, MTIME_LO, 32'h0);
    setR1(1'b1, 1'b0, 1'b0, MTIME_HI, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Locked 64-bit mtimecmp write by r1 while r0 keeps requesting.
    setR1(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setR1(1'b1, 1'b1, 1'b1, MTIMECMP_HI, 32'h0000_0000);
    applyStimulus(1'b0, 1'b1, 1'b0);
    setR1(1'b1, 1'b1, 1'b0, MTIMECMP_LO, 32'h0000_0100);
    applyStimulus(1'b0, 1'b1, 1'b0);
    setR1(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setR0(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkValue("mtimecmp_lo", tmr[2], 32'h0000_0100);
    checkValue("mtimecmp_hi", tmr[3], 32'h0000_0000);

    // Owner idles after locking; r1 waits.
    doReset();
    setR0(1'b1, 1'b0, 1'b1, MTIME_LO, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setR0(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    setR1(1'b1, 1'b0, 1'b0, MTIME_HI, 32'h0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef TIMER_ARB_TIMEOUT_EN
    applyStimulus(1'b0, 1'b1, 1'b1);
    setR1(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
`else
    applyStimulus(1'b0, 1'b0, 1'b0);
    setR0(1'b1, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setR0(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    setR1(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
`endif

    // Owner re-requests exactly on the terminal cycle.
    doReset();
    setR0(1'b1, 1'b0, 1'b1, MTIME_LO, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setR0(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    setR1(1'b1, 1'b0, 1'b0, MTIME_HI, 32'h0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    setR0(1'b1, 1'b0, 1'b1, MTIME_LO, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setR0(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setR0(1'b1, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setR0(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    setR1(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset while LOCKED1 with a read granted but not yet returned.
    doReset();
    setR1(1'b1, 1'b0, 1'b1, MTIME_HI, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    setR0(1'b1, 1'b0, 1'b0, MTIME_LO, 32'h0);
    setR1(1'b1, 1'b0, 1'b1, MTIME_LO, 32'h0);
    @(negedge clk);
    checkValue("locked1_r0_stall", 32'(r0_gnt), 32'd0);
    checkValue("locked1_r1_gnt", 32'(r1_gnt), 32'd1);
    resetb = 1'b0;
    #1;
    checkValue("rst_drop_rvalid", 32'(r1_rvalid), 32'd0);
    checkValue("rst_drop_rdata", r1_rdata, 32'd0);
    @(posedge clk);
    #1;
    checkValue("rst_no_late_rvalid", 32'(r1_rvalid), 32'd0);
    setR0(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    setR1(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    #1;
    setR0(1'b1, 1'b0, 1'b0, MTIME_LO, 32'h0);
    setR1(1'b1, 1'b0, 1'b0, MTIME_HI, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    setR0(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    setR1(1'b0, 1'b0, 1'b0, MTIME_LO, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/timer_io_arbiter.md
Name: timer_io_arbiter

Overview:
Two-requester arbiter in front of the 64-bit machine timer's 32-bit IO port (mtime at 0x80000010/14, mtimecmp at 0x80000018/1C). It shares the port between requester 0 (CPU load/store unit) and requester 1 (debug/loader master). It applies round-robin fairness. A lock lets one requester complete a two-word (hi/lo) 64-bit access sequence without the other interleaving.

Parameters:
LOCK_TIMEOUT, 16, idle cycles allowed for the lock owner before the lock is forcibly released (only used with TIMER_ARB_TIMEOUT_EN).
CNT_W, 5, width of the lock idle counter; must satisfy 2^CNT_W > LOCK_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
resetb  in  1  asynchronous active-low reset
r0_req  in  1  requester 0 access request; held with payload until granted
r0_we  in  1  requester 0 write enable (0 = read)
r0_lock  in  1  requester 0 keeps ownership after this access
r0_addr_3_2  in  2  requester 0 word select: 00 mtime lo, 01 mtime hi, 10 mtimecmp lo, 11 mtimecmp hi
r0_din  in  32  requester 0 write data
r0_gnt  out  1  requester 0 access accepted this cycle
r0_rdata  out  32  requester 0 read data
r0_rvalid  out  1  requester 0 read data valid, 1-cycle pulse
r1_*  same set as r0_* for requester 1
t_addr_3_2  out  2  timer word select
t_we  out  1  timer write strobe
t_din  out  32  timer write data
t_dout  in  32  timer read data (combinational from t_addr_3_2)
lock_timeout  out  1  1-cycle pulse when a lock is forcibly released

Behaviour:
- Clock/reset: single clock clk; asynchronous active-low reset resetb.
- State: UNLOCKED, LOCKED0, LOCKED1; prio register (0/1); idle counter.
- Reset values: state UNLOCKED, prio 0, counter 0, all gnt/rvalid/lock_timeout 0, rdata 0.
- Grant logic is combinational, same cycle as req. At most one gnt per cycle.
- UNLOCKED: single req is granted. Both req: grant requester == prio.
- LOCKEDi: only ri may be granted; the other requester's req stalls (gnt 0, payload held).
- t_addr_3_2/t_din follow the granted requester (requester 0 when none). t_we = granted we & gnt.
- Timer write lands at the next rising edge.
- Read latency 1: on the edge after a granted read, ri_rdata <= t_dout and ri_rvalid = 1 for one cycle. ri_rdata holds its value otherwise.
- Writes produce no rvalid.
- Granted access with lock=1: next state LOCKEDi, counter cleared. prio unchanged.
- Granted access with lock=0: next state UNLOCKED, prio <= other requester.
- In LOCKEDi, the counter increments each cycle ri_req=0 and clears on ri_req=1.
- Timeout: when the counter reaches LOCK_TIMEOUT, next state is UNLOCKED, prio <= other requester, and lock_timeout pulses one cycle.
- Simultaneous timeout and owner req in the same cycle: req wins (granted, counter cleared, no timeout).
- Counter saturates; it never wraps.
- Reset mid-lock or mid-read: immediate return to reset values; a pending rvalid is dropped.
- No address decoding here; the upstream decoder asserts ri_req only for timer addresses.

Optional Feature:
TIMER_ARB_TIMEOUT_EN
- Defined: idle counter and forced release as above; lock_timeout functional.
- Undefined: no counter logic; a lock persists until the owner issues a lock=0 access; lock_timeout tied 0; LOCK_TIMEOUT/CNT_W ignored.

Decomposition:
- Shared package: state encoding (UNLOCKED/LOCKED0/LOCKED1) and word-select constants (MTIME_LO=00, MTIME_HI=01, MTIMECMP_LO=10, MTIMECMP_HI=11).
- One sub-module: timer_arb_lock_counter (CNT_W counter with clear, enable, saturation, terminal flag vs LOCK_TIMEOUT), instantiated only under TIMER_ARB_TIMEOUT_EN.

Test Plan:
- Reset release, r0 read addr 00 while timer mtime lo = 0x5: r0_gnt same cycle; next cycle r0_rvalid=1, r0_rdata=0x5; r1 outputs stay 0.
- r0 and r1 request every cycle, lock=0 → grants alternate 0,1,0,1 starting with r0 after reset.
- r1 writes 0x0 to 11 with lock=1, then 0x100 to 10 with lock=0; r0 requests throughout → r0 stalled both cycles, r0 granted on the cycle after r1's second grant; timer mtimecmp = 0x0_00000100.
- TIMER_ARB_TIMEOUT_EN defined, LOCK_TIMEOUT=16: r0 locks, then idles → lock_timeout pulses; r1 is granted on the cycle the lock is released; without the macro r1 is never granted.
- resetb asserted in LOCKED1 with a read outstanding → no rvalid; after release, state UNLOCKED, prio 0.
- Owner re-requests on the exact timeout cycle → granted, no lock_timeout pulse.
